// File: rtl/wb_fifo_slave_if.sv
// Wishbone bus bundle between the host-interface master and the loopback FIFO responder.
interface wb_fifo_slave_if;
    logic        i_wbs_cyc;
    logic        i_wbs_stb;
    logic        i_wbs_we;
    logic [3:0]  i_wbs_sel;
    logic [31:0] i_wbs_adr;
    logic [31:0] i_wbs_dat;
    logic [31:0] o_wbs_dat;
    logic        o_wbs_ack;
    logic        o_wbs_int;

    modport slave (
        input  i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_sel, i_wbs_adr, i_wbs_dat,
        output o_wbs_dat, o_wbs_ack, o_wbs_int
    );

    modport master (
        output i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_sel, i_wbs_adr, i_wbs_dat,
        input  o_wbs_dat, o_wbs_ack, o_wbs_int
    );
endinterface

// File: rtl/wb_fifo_slave.sv
// Wishbone responder exposing a 32-bit loopback FIFO via CONTROL/STATUS/DATA/THRESHOLD
// word registers, with a level interrupt on threshold or sticky over/underflow.
module wb_fifo_slave #(
    parameter int DEPTH_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_fifo_slave_if.slave    wbs
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);

    localparam logic [1:0] ADR_CTRL = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd1;
    localparam logic [1:0] ADR_DATA = 2'd2;
    localparam logic [1:0] ADR_THR  = 2'd3;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_BITS-1:0] rptr, wptr;
    logic [DEPTH_BITS:0]   count, threshold;
    logic                  int_en, ovf, unf;

    logic        accept, full, empty, thr;
    logic [1:0]  adr;
    logic [31:0] status, rd_data;
    logic        unused;

    assign adr    = wbs.i_wbs_adr[1:0];
    // A strobe is taken only while ack is low, so a held strobe costs exactly one access.
    assign accept = wbs.i_wbs_cyc & wbs.i_wbs_stb & ~wbs.o_wbs_ack;
    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign thr    = (count >= threshold);
    assign unused = ^{wbs.i_wbs_sel, wbs.i_wbs_adr[31:2]};

    always_comb begin
        status                 = '0;
        status[DEPTH_BITS:0]   = count;
        status[16]             = empty;
        status[17]             = full;
        status[18]             = ovf;
        status[19]             = unf;
        status[20]             = thr;
    end

    always_comb begin
        rd_data = '0;
        case (adr)
            ADR_CTRL: rd_data = {31'd0, int_en};
            ADR_STAT: rd_data = status;
            ADR_DATA: rd_data = empty ? 32'd0 : mem[rptr];
            ADR_THR:  rd_data = {{(31-DEPTH_BITS){1'b0}}, threshold};
            default:  rd_data = '0;
        endcase
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (accept && wbs.i_wbs_we && adr == ADR_DATA && !full)
            mem[wptr] <= wbs.i_wbs_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs.o_wbs_ack <= 1'b0;
            wbs.o_wbs_dat <= '0;
            wbs.o_wbs_int <= 1'b0;
            rptr          <= '0;
            wptr          <= '0;
            count         <= '0;
            threshold     <= DEPTH_CNT;
            int_en        <= 1'b0;
            ovf           <= 1'b0;
            unf           <= 1'b0;
        end else begin
            wbs.o_wbs_ack <= accept | (wbs.o_wbs_ack & wbs.i_wbs_stb);
            wbs.o_wbs_int <= int_en & (thr | ovf | unf);
            if (accept && !wbs.i_wbs_we)
                wbs.o_wbs_dat <= rd_data;
            if (accept) begin
                case (adr)
                    ADR_CTRL: if (wbs.i_wbs_we) begin
                        int_en <= wbs.i_wbs_dat[0];
                        if (wbs.i_wbs_dat[1]) begin
                            rptr  <= '0;
                            wptr  <= '0;
                            count <= '0;
                            ovf   <= 1'b0;
                            unf   <= 1'b0;
                        end
                    end
                    // Flags were latched into o_wbs_dat at this same edge before clearing.
                    ADR_STAT: if (!wbs.i_wbs_we) begin
                        ovf <= 1'b0;
                        unf <= 1'b0;
                    end
                    ADR_DATA: if (wbs.i_wbs_we) begin
                        if (full) ovf <= 1'b1;
                        else begin
                            wptr  <= wptr + PTR_ONE;
                            count <= count + CNT_ONE;
                        end
                    end else begin
                        if (empty) unf <= 1'b1;
                        else begin
                            rptr  <= rptr + PTR_ONE;
                            count <= count - CNT_ONE;
                        end
                    end
                    ADR_THR: if (wbs.i_wbs_we) threshold <= wbs.i_wbs_dat[DEPTH_BITS:0];
                    default: ;
                endcase
            end
        end
    end
endmodule
